// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter merging CPU memory requesters onto one req/ack memory port.
// Define ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES cycles without ack.
module mem_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_CH-1:0]      i_ch_req,
    input  logic [NUM_CH*XLEN-1:0] i_ch_addr,
    input  logic [NUM_CH*XLEN-1:0] i_ch_wdata,
    input  logic [NUM_CH*3-1:0]    i_ch_funct3,
    input  logic [NUM_CH-1:0]      i_ch_we,
    output logic [NUM_CH-1:0]      o_ch_ack,
    output logic [XLEN-1:0]        o_ch_rdata,
    output logic [NUM_CH-1:0]      o_ch_err,
    output logic                   o_mem_req,
    output logic [XLEN-1:0]        o_mem_addr,
    output logic [XLEN-1:0]        o_mem_wdata,
    output logic [2:0]             o_mem_funct3,
    output logic                   o_mem_we,
    input  logic                   i_mem_ack,
    input  logic [XLEN-1:0]        i_mem_rdata
);

    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  grant_q, grant_d;
    logic              req_d;
    logic [XLEN-1:0]   addr_d, wdata_d, rdata_d;
    logic [2:0]        funct3_d;
    logic              we_d;
    logic [NUM_CH-1:0] ack_d;
    logic              found;
    logic [PTR_W-1:0]  pick;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NUM_CH-1:0] err_d;
`endif

    // Wrap is explicit so non-power-of-2 channel counts never reach an unused index.
    function automatic logic [PTR_W-1:0] next_ch(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_CH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic void pick_first(input  logic [NUM_CH-1:0] req,
                                       input  logic [PTR_W-1:0]  start,
                                       output logic              hit,
                                       output logic [PTR_W-1:0]  idx);
        logic [PTR_W-1:0] cand;
        hit  = 1'b0;
        idx  = start;
        cand = start;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
            cand = next_ch(cand);
        end
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        req_d    = o_mem_req;
        addr_d   = o_mem_addr;
        wdata_d  = o_mem_wdata;
        funct3_d = o_mem_funct3;
        we_d     = o_mem_we;
        rdata_d  = o_ch_rdata;
        ack_d    = '0;
`ifdef ARB_TIMEOUT_EN
        err_d    = '0;
        tmo_d    = tmo_q;
`endif
        pick_first(i_ch_req, ptr_q, found, pick);

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    req_d    = 1'b1;
                    addr_d   = i_ch_addr[int'(pick)*XLEN +: XLEN];
                    wdata_d  = i_ch_wdata[int'(pick)*XLEN +: XLEN];
                    funct3_d = i_ch_funct3[int'(pick)*3 +: 3];
                    we_d     = i_ch_we[pick];
                    state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            BUSY: begin
                // An ack arriving in the expiry cycle takes precedence over the abort.
                if (i_mem_ack) begin
                    ack_d[grant_q] = 1'b1;
                    rdata_d        = i_mem_rdata;
                    req_d          = 1'b0;
                    ptr_d          = next_ch(grant_q);
                    state_d        = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    rdata_d        = '0;
                    req_d          = 1'b0;
                    ptr_d          = next_ch(grant_q);
                    state_d        = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (i_rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            o_mem_req    <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_funct3 <= '0;
            o_mem_we     <= 1'b0;
            o_ch_ack     <= '0;
            o_ch_rdata   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            o_mem_req    <= req_d;
            o_mem_addr   <= addr_d;
            o_mem_wdata  <= wdata_d;
            o_mem_funct3 <= funct3_d;
            o_mem_we     <= we_d;
            o_ch_ack     <= ack_d;
            o_ch_rdata   <= rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q    <= '0;
            o_ch_err <= '0;
        end else begin
            tmo_q    <= tmo_d;
            o_ch_err <= err_d;
        end
    end
`else
    assign o_ch_err = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed latency/priority/reset/timeout steps,
// then randomized traffic checked against a transaction-level round-robin model.
module tb_mem_arbiter;

    localparam int NCH = 4;
    localparam int XL  = 32;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req;
    logic [NCH*XL-1:0] ch_addr, ch_wdata;
    logic [NCH*3-1:0]  ch_funct3;
    logic [NCH-1:0]    ch_we;
    logic [NCH-1:0]    o_ch_ack, o_ch_err;
    logic [XL-1:0]     o_ch_rdata;
    logic              o_mem_req, o_mem_we;
    logic [XL-1:0]     o_mem_addr, o_mem_wdata;
    logic [2:0]        o_mem_funct3;
    logic              mem_ack;
    logic [XL-1:0]     mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level)
    int          m_busy, m_ptr, m_delay;
    bit          m_resp, m_acked;
    logic [31:0] m_rdata, e_addr, e_wdata;
    logic [2:0]  e_f3;
    logic        e_we;
    bit          active [NCH];
    int          issued [NCH];
    int          done_n [NCH];

    mem_arbiter #(.NUM_CH(NCH), .XLEN(XL), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ch_req(ch_req), .i_ch_addr(ch_addr), .i_ch_wdata(ch_wdata),
        .i_ch_funct3(ch_funct3), .i_ch_we(ch_we),
        .o_ch_ack(o_ch_ack), .o_ch_rdata(o_ch_rdata), .o_ch_err(o_ch_err),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_funct3(o_mem_funct3), .o_mem_we(o_mem_we),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input logic we);
        ch_addr[c*XL +: XL]  = a;
        ch_wdata[c*XL +: XL] = wd;
        ch_funct3[c*3 +: 3]  = f3;
        ch_we[c]             = we;
    endtask

    // Waits (bounded) for a grant, checks it belongs to channel ch, acks after delay cycles.
    task automatic do_txn(input int ch, input int delay, input logic [31:0] rd, input string tag);
        int w;
        logic [31:0] exp_addr;
        exp_addr = ch_addr[ch*XL +: XL];
        w = 0;
        while (o_mem_req !== 1'b1 && w < 8) begin
            step();
            w++;
        end
        check({tag, "_req"}, o_mem_req, 1'b1);
        check({tag, "_grant_addr"}, o_mem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            step();
            check({tag, "_hold_req"}, o_mem_req, 1'b1);
            check({tag, "_hold_addr"}, o_mem_addr, exp_addr);
            check({tag, "_no_early_ack"}, o_ch_ack, '0);
        end
        mem_ack    = 1'b1;
        mem_rdata  = rd;
        ch_req[ch] = 1'b0;
        step();
        mem_ack = 1'b0;
        check({tag, "_ack"}, o_ch_ack, 64'd1 << ch);
        check({tag, "_rdata"}, o_ch_rdata, rd);
        check({tag, "_err"}, o_ch_err, '0);
        check({tag, "_req_drop"}, o_mem_req, 1'b0);
        step();
        check({tag, "_ack_1cyc"}, o_ch_ack, '0);
        check({tag, "_rdata_hold"}, o_ch_rdata, rd);
        check({tag, "_idle_req"}, o_mem_req, 1'b0);
    endtask

    // One cycle of random traffic: update model for the edge just taken, compare, drive next inputs.
    task automatic rand_cycle(input bit allow_new);
        logic [NCH-1:0] e_ack;
        int c;
        step();
        e_ack = '0;
        if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_busy < 0) begin
            for (int i = 0; i < NCH; i++) begin
                c = (m_ptr + i) % NCH;
                if (m_busy < 0 && ch_req[c]) begin
                    m_busy  = c;
                    e_addr  = ch_addr[c*XL +: XL];
                    e_wdata = ch_wdata[c*XL +: XL];
                    e_f3    = ch_funct3[c*3 +: 3];
                    e_we    = ch_we[c];
                end
            end
        end else if (mem_ack) begin
            e_ack[m_busy] = 1'b1;
            m_rdata = mem_rdata;
            m_ptr   = (m_busy + 1) % NCH;
            m_busy  = -1;
            m_resp  = 1'b1;
        end
        check("rnd_mem_req", o_mem_req, m_busy >= 0);
        if (m_busy >= 0) begin
            check("rnd_addr", o_mem_addr, e_addr);
            check("rnd_wdata", o_mem_wdata, e_wdata);
            check("rnd_funct3", o_mem_funct3, e_f3);
            check("rnd_we", o_mem_we, e_we);
        end
        check("rnd_ack", o_ch_ack, e_ack);
        check("rnd_rdata", o_ch_rdata, m_rdata);
        check("rnd_err", o_ch_err, '0);

        mem_ack = 1'b0;
        if (o_mem_req) begin
            if (!m_acked) begin
                if (m_delay == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                    m_acked   = 1'b1;
                end else begin
                    m_delay--;
                end
            end
        end else begin
            m_acked = 1'b0;
            m_delay = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end

        for (int k = 0; k < NCH; k++) begin
            if (o_ch_ack[k]) begin
                active[k] = 1'b0;
                ch_req[k] = 1'b0;
                done_n[k]++;
            end else if (allow_new && !active[k] && $urandom_range(0, 2) == 0) begin
                active[k] = 1'b1;
                ch_req[k] = 1'b1;
                set_ch(k, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                issued[k]++;
            end else if (active[k] && ch_req[k] && m_busy == k && $urandom_range(0, 9) == 0) begin
                ch_req[k] = 1'b0;
            end
        end
    endtask

    initial begin
        int ng, cyc, cnt, n_acks, last_g;
        bit acked, prev, drained;

        rst = 1'b1; ch_req = '0; ch_addr = '0; ch_wdata = '0; ch_funct3 = '0; ch_we = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        step();
        step();
        check("rst_mem_req", o_mem_req, 1'b0);
        check("rst_mem_addr", o_mem_addr, '0);
        check("rst_ch_ack", o_ch_ack, '0);
        check("rst_rdata", o_ch_rdata, '0);
        check("rst_err", o_ch_err, '0);
        rst = 1'b0;

        // Read on ch0, memory acks two cycles after the request appears
        set_ch(0, 32'h100, 32'h0, 3'b010, 1'b0);
        ch_req[0] = 1'b1;
        step();
        check("t1_latency_req", o_mem_req, 1'b1);
        check("t1_we", o_mem_we, 1'b0);
        do_txn(0, 2, 32'hDEADBEEF, "t1");

        // All channels requesting continuously from reset: strict rotation
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) set_ch(c, 32'h1000 + 32'(c) * 32'h10, 32'h0, 3'b010, 1'b0);
        ch_req = '1;
        ng = 0; cyc = 0; cnt = 0; n_acks = 0; last_g = 0; acked = 1'b0; prev = 1'b0;
        while (ng < 8 && cyc < 80) begin
            step();
            cyc++;
            mem_ack = 1'b0;
            if (o_ch_ack != '0) begin
                check("t2_ack_onehot", o_ch_ack, 64'd1 << last_g);
                n_acks++;
            end
            if (o_mem_req && !prev) begin
                check("t2_grant_order", o_mem_addr, 32'h1000 + 32'(ng % NCH) * 32'h10);
                last_g = ng % NCH;
                ng++;
                acked = 1'b0;
                cnt = 0;
            end else if (o_mem_req && !acked) begin
                mem_ack = 1'b1;
                mem_rdata = 32'(cyc);
                acked = 1'b1;
            end
            prev = o_mem_req;
        end
        check("t2_grant_count", ng, 8);
        check("t2_ack_count", n_acks, 7);
        ch_req = '0;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("t2_last_ack", o_ch_ack, 4'b1000);
        step();

        // Last grant ch2, then ch1 and ch3 compete: ch3 wins first
        set_ch(2, 32'h2200, 32'h0, 3'b000, 1'b0);
        ch_req[2] = 1'b1;
        do_txn(2, 0, 32'h22222222, "t3_ch2");
        set_ch(1, 32'h2100, 32'h0, 3'b001, 1'b0);
        set_ch(3, 32'h2300, 32'h0, 3'b100, 1'b0);
        ch_req[1] = 1'b1;
        ch_req[3] = 1'b1;
        do_txn(3, 1, 32'h33333333, "t3_ch3");
        do_txn(1, 0, 32'h11111111, "t3_ch1");

        // ch1 write, request dropped mid-BUSY
        set_ch(1, 32'h2000, 32'h12345678, 3'b010, 1'b1);
        ch_req[1] = 1'b1;
        step();
        check("t4_req", o_mem_req, 1'b1);
        check("t4_addr", o_mem_addr, 32'h2000);
        check("t4_wdata", o_mem_wdata, 32'h12345678);
        check("t4_funct3", o_mem_funct3, 3'b010);
        check("t4_we", o_mem_we, 1'b1);
        ch_req[1] = 1'b0;
        set_ch(1, 32'hFFFF, 32'hFFFF, 3'b111, 1'b0);
        repeat (2) begin
            step();
            check("t4_hold_req", o_mem_req, 1'b1);
            check("t4_hold_addr", o_mem_addr, 32'h2000);
            check("t4_hold_wdata", o_mem_wdata, 32'h12345678);
            check("t4_hold_we", o_mem_we, 1'b1);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        check("t4_ack", o_ch_ack, 4'b0010);
        check("t4_rdata", o_ch_rdata, 32'hCAFEF00D);
        step();

        // Reset during BUSY, then a stray memory ack
        set_ch(2, 32'h3000, 32'h0, 3'b010, 1'b0);
        ch_req[2] = 1'b1;
        step();
        check("t5_busy", o_mem_req, 1'b1);
        rst = 1'b1;
        ch_req = '0;
        step();
        check("t5_rst_req", o_mem_req, 1'b0);
        check("t5_rst_addr", o_mem_addr, '0);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h00000BAD;
        step();
        mem_ack = 1'b0;
        check("t5_stray_ack", o_ch_ack, '0);
        check("t5_stray_req", o_mem_req, 1'b0);
        check("t5_stray_rdata", o_ch_rdata, '0);
        set_ch(0, 32'h4000, 32'h0, 3'b010, 1'b0);
        set_ch(3, 32'h4300, 32'h0, 3'b010, 1'b0);
        ch_req = 4'b1001;
        do_txn(0, 0, 32'h40404040, "t5_ptr0");
        do_txn(3, 0, 32'h43434343, "t5_ch3");

        // Memory never acks ch0
        set_ch(0, 32'h5000, 32'h0, 3'b010, 1'b0);
        ch_req[0] = 1'b1;
        step();
        for (int i = 1; i <= TMO; i++) begin
            check("t6_busy_req", o_mem_req, 1'b1);
            check("t6_busy_ack", o_ch_ack, '0);
            step();
        end
`ifdef ARB_TIMEOUT_EN
        check("t6_to_ack", o_ch_ack, 4'b0001);
        check("t6_to_err", o_ch_err, 4'b0001);
        check("t6_to_rdata", o_ch_rdata, '0);
        check("t6_to_req", o_mem_req, 1'b0);
        ch_req[0] = 1'b0;
        step();
        check("t6_to_ack_1cyc", o_ch_ack, '0);
        check("t6_to_err_1cyc", o_ch_err, '0);
`else
        check("t6_wait_req", o_mem_req, 1'b1);
        check("t6_wait_ack", o_ch_ack, '0);
        repeat (4) begin
            step();
            check("t6_wait_req", o_mem_req, 1'b1);
            check("t6_wait_err", o_ch_err, '0);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        ch_req[0] = 1'b0;
        step();
        mem_ack = 1'b0;
        check("t6_late_ack", o_ch_ack, 4'b0001);
        check("t6_late_err", o_ch_err, '0);
        step();
`endif
        // Ack arriving in the last allowed BUSY cycle completes normally
        set_ch(1, 32'h6100, 32'h0, 3'b010, 1'b0);
        ch_req[1] = 1'b1;
        do_txn(1, TMO - 1, 32'h61616161, "t6_edge");

        // Randomized traffic against the transaction-level model
        rst = 1'b1;
        ch_req = '0;
        mem_ack = 1'b0;
        step();
        rst = 1'b0;
        m_busy = -1; m_ptr = 0; m_resp = 1'b0; m_acked = 1'b0; m_delay = 0; m_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            active[k] = 1'b0;
            issued[k] = 0;
            done_n[k] = 0;
        end
        for (int n = 0; n < 600; n++) rand_cycle(1'b1);
        drained = 1'b0;
        for (int n = 0; n < 300 && !drained; n++) begin
            rand_cycle(1'b0);
            drained = (m_busy < 0) && !m_resp;
            for (int k = 0; k < NCH; k++) if (active[k]) drained = 1'b0;
        end
        check("rnd_drained", drained, 1'b1);
        for (int k = 0; k < NCH; k++) check("rnd_complete", done_n[k], issued[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised N-channel round-robin arbiter that merges CPU memory requesters (instruction fetch, data access, and future requesters such as a CSR/debug port) onto a single req/ack memory port. It sits between the pipeline top level and the external memory controller. It replaces point-to-point fetch and data ports with one shared bus. Each transaction is latched at grant, held stable until the memory acks, then returned to the winning channel.

Parameters:
NUM_CH, 2, number of requester channels (>= 2); channel 0 wins ties after reset
XLEN, 32, address/data width
TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  CPU clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_ch_req  in  NUM_CH  per-channel request; held high until that channel's ack
i_ch_addr  in  NUM_CH*XLEN  per-channel address; channel c at bits [c*XLEN +: XLEN]
i_ch_wdata  in  NUM_CH*XLEN  per-channel write data, same packing
i_ch_funct3  in  NUM_CH*3  per-channel size/sign code (RV32I load/store funct3)
i_ch_we  in  NUM_CH  per-channel write (1) / read (0)
o_ch_ack  out  NUM_CH  one-cycle completion pulse to the granted channel
o_ch_rdata  out  XLEN  read data, valid in the o_ch_ack cycle; shared by all channels
o_ch_err  out  NUM_CH  one-cycle error pulse coincident with ack (timeout only)
o_mem_req  out  1  memory request
o_mem_addr  out  XLEN  memory address
o_mem_wdata  out  XLEN  memory write data
o_mem_funct3  out  3  memory size code
o_mem_we  out  1  memory write (1) / read (0)
i_mem_ack  in  1  memory completion, single-cycle pulse
i_mem_rdata  in  XLEN  memory read data, valid with i_mem_ack

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, priority pointer=0, all outputs 0 (o_mem_*, o_ch_ack, o_ch_rdata, o_ch_err). Any in-flight transaction is discarded. Reset overrides every other input.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE: if any i_ch_req bit is high, grant the first requesting channel scanning ptr, ptr+1, ... (mod NUM_CH).
  - Latch that channel's addr, wdata, funct3 and we into o_mem_*.
  - Set o_mem_req=1 and record the grant index g; next state BUSY.
  - If no request is high, stay in IDLE.
- BUSY: o_mem_req and all o_mem_* fields are held constant.
  - On i_mem_ack=1: next cycle o_ch_ack[g]=1, o_ch_rdata=i_mem_rdata (writes also capture it), o_mem_req=0, ptr=(g+1) mod NUM_CH; next state RESP.
- RESP: lasts exactly one cycle; o_ch_ack/o_ch_err are high only here. No arbitration occurs in RESP; next state IDLE. o_ch_rdata holds its value until the next RESP.
- Requester rule: deassert i_ch_req by the cycle after ack. A request still high in IDLE counts as a new transaction.
- Minimum latency: req seen in IDLE at cycle 0; o_mem_req high from cycle 1; ack at cycle k (k>=1) gives o_ch_ack at cycle k+1. Peak throughput is one transaction per 3 cycles.
- If i_ch_req[g] drops during BUSY, the transaction still completes and is still acked.
- i_mem_ack outside BUSY is ignored.
- Requests from non-granted channels arriving during BUSY/RESP wait; no request is lost or reordered within a channel.
- Fairness: with all NUM_CH channels requesting continuously, grants rotate 0,1,...,NUM_CH-1,0,...
- Pointer width is $clog2(NUM_CH); wrap from NUM_CH-1 to 0 is explicit (non-power-of-2 NUM_CH is legal).

Optional Feature:
ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - If BUSY reaches TIMEOUT_CYCLES cycles with no ack: o_mem_req drops, the next cycle is RESP with o_ch_ack[g]=1, o_ch_err[g]=1, o_ch_rdata=0, and ptr advances.
  - An ack in the same cycle as expiry wins (normal completion, no error).
- Undefined: no counter; o_ch_err is tied to 0; BUSY waits indefinitely.

Test Plan:
- NUM_CH=2, ch0 read addr 0x100, mem acks 2 cycles after o_mem_req with 0xDEADBEEF -> o_mem_req high cycles 1-3, o_ch_ack[0] and o_ch_rdata=0xDEADBEEF at cycle 4, ack high 1 cycle.
- Both channels request continuously from reset, mem acks 1 cycle after each req -> grant order 0,1,0,1; no double grant; ptr alternates.
- NUM_CH=4, last grant ch2, ch1 and ch3 requesting -> ch3 granted first, then ch1.
- ch1 write: addr 0x2000, wdata 0x12345678, funct3=3'b010, we=1; ch1 drops req mid-BUSY -> o_mem_* exactly those values and stable until ack; o_ch_ack[1] still pulses.
- i_rst asserted during BUSY, then stray i_mem_ack next cycle -> o_mem_req=0 and ptr=0 after that edge; stray ack produces no o_ch_ack.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ch0 req at cycle 0, no ack -> BUSY cycles 1-8, cycle 9 o_ch_ack[0]=o_ch_err[0]=1, o_ch_rdata=0; without the macro, o_mem_req stays high and o_ch_err stays 0.
